// File: rtl/fuzz_stim_misr.sv
// fuzz_stim_misr: seeded 64-bit LFSR stimulus generator feeding a DUT, with a 32-bit MISR
// compacting the DUT response. Define FUZZ_GOLDEN_CMP_EN to compile in the golden-signature comparator.
module fuzz_stim_misr #(
  parameter int unsigned IN_W  = 53,
  parameter int unsigned OUT_W = 567,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] vec_count,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [31:0]      golden_sig,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic             match
);

  localparam int unsigned REP    = (IN_W + 63) / 64;
  localparam int unsigned CHUNKS = (OUT_W + 31) / 32;
  localparam int unsigned PAD_W  = CHUNKS * 32;
  localparam int unsigned DRN_W  = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SIG_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, ZERO, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [63:0]       lfsr;
  logic [CNT_W-1:0]  remain;
  logic [DRN_W-1:0]  drain_cnt;
  logic              stim_vld;
  logic [LAT-1:0]    vld_pipe;

  logic [REP*64-1:0] rep_c;
  logic [PAD_W-1:0]  out_pad_c;
  logic [31:0]       fold_c;
  logic [31:0]       sig_next_c;
  logic              accept_c;
  logic              match_c;

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 64'h0);
  endfunction

  // Stimulus is the LFSR state tiled across the whole input bus.
  always_comb begin
    rep_c = {REP{lfsr}};
  end

  // Response compaction: XOR of all 32-bit slices, top slice zero-padded.
  always_comb begin
    out_pad_c = PAD_W'(dut_out);
    fold_c    = '0;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      fold_c = fold_c ^ out_pad_c[i*32 +: 32];
    end
  end

  always_comb begin
    sig_next_c = signature;
    if (vld_pipe[LAT-1]) begin
      sig_next_c = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ fold_c;
    end
  end

  assign accept_c = start && ((state == IDLE) || (state == DONE));

`ifdef FUZZ_GOLDEN_CMP_EN
  // Compare against the signature value being written on the DONE-entry edge.
  assign match_c = (sig_next_c == golden_sig);
`else
  logic unused_golden;
  assign unused_golden = ^golden_sig;
  assign match_c       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= 64'h1;
      remain    <= '0;
      drain_cnt <= '0;
      stim_vld  <= 1'b0;
      vld_pipe  <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= SIG_INIT;
      match     <= 1'b0;
    end else begin
      signature   <= sig_next_c;
      vld_pipe[0] <= stim_vld;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            state     <= ZERO;
            lfsr      <= (seed == 64'h0) ? 64'h1 : seed;
            remain    <= vec_count;
            signature <= SIG_INIT;
            busy      <= 1'b1;
            done      <= 1'b0;
            match     <= 1'b0;
            dut_in    <= '0;
            stim_vld  <= 1'b1;
          end
        end

        // ZERO and RUN share one rule: issue the next LFSR vector or fall into DRAIN.
        ZERO, RUN: begin
          if (remain == '0) begin
            state     <= DRAIN;
            dut_in    <= '0;
            stim_vld  <= 1'b0;
            drain_cnt <= '0;
          end else begin
            state    <= RUN;
            dut_in   <= rep_c[IN_W-1:0];
            stim_vld <= 1'b1;
            lfsr     <= lfsr_step(lfsr);
            remain   <= remain - CNT_W'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == DRN_W'(LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= match_c;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_stim_misr.sv
// Bench for fuzz_stim_misr: a LAT=1/IN_W=53 instance and a LAT=3/IN_W=64 instance driven in
// lockstep, each with a registered zero-extending DUT; expected stimulus queued per run.
module tb_fuzz_stim_misr;

  localparam int unsigned OUT_W = 567;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IN_A  = 53;
  localparam int unsigned IN_B  = 64;
  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [63:0] MASK_A = 64'h001F_FFFF_FFFF_FFFF;
  localparam logic [31:0] SIG0   = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, top_mode;
  logic [63:0]      seed;
  logic [CNT_W-1:0] vec_count;
  logic [31:0]      golden_sig;

  logic [IN_A-1:0]  dut_in_a;
  logic [IN_B-1:0]  dut_in_b;
  logic [OUT_W-1:0] ext_a, ext_b, dut_out_a, dut_out_b, pipe_b1, pipe_b2;
  logic             busy_a, done_a, match_a, busy_b, done_b, match_b;
  logic [31:0]      sig_a, sig_b;

  int n_vec = 0;
  int n_err = 0;

  fuzz_stim_misr #(.IN_W(IN_A), .OUT_W(OUT_W), .LAT(LAT_A), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .vec_count(vec_count),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .golden_sig(golden_sig),
    .busy(busy_a), .done(done_a), .signature(sig_a), .match(match_a)
  );

  fuzz_stim_misr #(.IN_W(IN_B), .OUT_W(OUT_W), .LAT(LAT_B), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .vec_count(vec_count),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .golden_sig(golden_sig),
    .busy(busy_b), .done(done_b), .signature(sig_b), .match(match_b)
  );

  // DUT stand-ins: zero-extended stimulus, optionally mirrored into the padded top slice.
  always_comb begin
    ext_a = '0;
    ext_a[IN_A-1:0] = dut_in_a;
    if (top_mode) ext_a[OUT_W-1 -: 23] = ext_a[OUT_W-1 -: 23] ^ dut_in_a[22:0];
    ext_b = '0;
    ext_b[IN_B-1:0] = dut_in_b;
    if (top_mode) ext_b[OUT_W-1 -: 23] = ext_b[OUT_W-1 -: 23] ^ dut_in_b[22:0];
  end

  always @(posedge clk) begin
    dut_out_a <= ext_a;
    pipe_b1   <= ext_b;
    pipe_b2   <= pipe_b1;
    dut_out_b <= pipe_b2;
  end

  function automatic logic [63:0] step(input logic [63:0] l);
    return {1'b0, l[63:1]} ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] fold(input logic [63:0] v, input bit top);
    return v[31:0] ^ v[63:32] ^ (top ? {9'b0, v[22:0]} : 32'h0);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [63:0] s, input int vc, input logic [31:0] g,
                     input bit gold_self, input bit top, input bit poke);
    logic [63:0] l, v;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [31:0] es_a, es_b;
    bit          m_a, m_b;
    int          k_a, k_b;
    l    = (s == 64'h0) ? 64'h1 : s;
    v    = 64'h0;
    es_a = SIG0;
    es_b = SIG0;
    for (int i = 0; i <= vc; i++) begin
      if (i > 0) begin
        v = l;
        l = step(l);
      end
      qa.push_back(v & MASK_A);
      qb.push_back(v);
      es_a = misr(es_a, fold(v & MASK_A, top));
      es_b = misr(es_b, fold(v, top));
    end
    golden_sig = gold_self ? es_a : g;
`ifdef FUZZ_GOLDEN_CMP_EN
    m_a = (es_a == golden_sig);
    m_b = (es_b == golden_sig);
`else
    m_a = 1'b0;
    m_b = 1'b0;
`endif
    seed      = s;
    vec_count = CNT_W'(vc);
    top_mode  = top;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k_a   = 0;
    k_b   = 0;
    for (int k = 1; k <= vc + 12; k++) begin
      // A start (with different operands) while busy must change nothing.
      if (poke) begin
        start = (k == 3);
        if (k == 3) begin
          seed      = ~s;
          vec_count = CNT_W'(3);
        end
      end
      if (qa.size() != 0) check_val("dut_in_a", 64'(dut_in_a), qa.pop_front());
      else if (k_a == 0) check_val("drain_in_a", 64'(dut_in_a), 64'h0);
      if (qb.size() != 0) check_val("dut_in_b", 64'(dut_in_b), qb.pop_front());
      else if (k_b == 0) check_val("drain_in_b", 64'(dut_in_b), 64'h0);
      if (k_a == 0) begin
        if (done_a) k_a = k;
        else check_val("busy_a", 64'(busy_a), 64'h1);
      end
      if (k_b == 0) begin
        if (done_b) k_b = k;
        else check_val("busy_b", 64'(busy_b), 64'h1);
      end
      @(negedge clk);
    end
    check_val("done_cycle_a", 64'(k_a), 64'(vc + LAT_A + 2));
    check_val("done_cycle_b", 64'(k_b), 64'(vc + LAT_B + 2));
    check_val("done_held_a", 64'(done_a), 64'h1);
    check_val("busy_end_b", 64'(busy_b), 64'h0);
    check_val("sig_a", 64'(sig_a), 64'(es_a));
    check_val("sig_b", 64'(sig_b), 64'(es_b));
    check_val("match_a", 64'(match_a), 64'(m_a));
    check_val("match_b", 64'(match_b), 64'(m_b));
  endtask

  task automatic reset_mid_run(input logic [63:0] s);
    seed       = s;
    vec_count  = CNT_W'(20);
    golden_sig = 32'h0;
    top_mode   = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("busy_pre_rst", 64'(busy_a), 64'h1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_val("rst_busy_a", 64'(busy_a), 64'h0);
    check_val("rst_done_a", 64'(done_a), 64'h0);
    check_val("rst_sig_a", 64'(sig_a), 64'(SIG0));
    check_val("rst_in_a", 64'(dut_in_a), 64'h0);
    check_val("rst_busy_b", 64'(busy_b), 64'h0);
    check_val("rst_sig_b", 64'(sig_b), 64'(SIG0));
    check_val("rst_in_b", 64'(dut_in_b), 64'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_val("idle_after_rst", 64'(busy_a), 64'h0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    seed       = 64'h0;
    vec_count  = '0;
    golden_sig = 32'h0;
    top_mode   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_in_a", 64'(dut_in_a), 64'h0);
    check_val("reset_busy_a", 64'(busy_a), 64'h0);
    check_val("reset_done_a", 64'(done_a), 64'h0);
    check_val("reset_sig_a", 64'(sig_a), 64'(SIG0));
    check_val("reset_match_a", 64'(match_a), 64'h0);
    check_val("reset_sig_b", 64'(sig_b), 64'(SIG0));
    rst = 1'b0;
    @(negedge clk);

    // Zero-vector-only run: known signature, golden matching and not matching.
    run(64'h1, 0, 32'hFB3E_E249, 1'b0, 1'b0, 1'b0);
    check_val("sig_zero_run", 64'(sig_a), 64'h0000_0000_FB3E_E249);
    run(64'h1, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    // seed 1 and seed 0 must produce identical runs.
    run(64'h1, 2, 32'h0, 1'b0, 1'b0, 1'b0);
    run(64'h0, 2, 32'h0, 1'b0, 1'b0, 1'b0);
    run(64'h0123_4567_89AB_CDEF, 40, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run({$urandom, $urandom}, int'($urandom_range(5, 60)), 32'h0, 1'(r & 1), 1'b1, 1'b0);
    end
    reset_mid_run(64'hDEAD_BEEF_0000_0001);
    run(64'hDEAD_BEEF_0000_0001, 20, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
